// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// stream_mux_rr_if : producer/consumer stream bundle for the N:1 stream mux
// Rev 1.0
// ============================================================================
interface stream_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : N-channel stream mux, round-robin or fixed select,
//                 registered single-entry output stage
// Rev 1.0
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    stream_mux_rr_if.slave    bus
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic [WIDTH-1:0] w_gdata;
    logic             w_found;
    logic [N-1:0]     w_in_ready;
    logic             w_xfer;

    assign w_load_en = !r_out_valid | bus.out_ready;

    // Round-robin: two passes (channels at/above the pointer, then below) give
    // the wrapped upward search without variable-index arithmetic.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_gdata = '0;
        w_found = 1'b0;
        if (bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (int'(bus.sel) == i) begin
                    w_grant[i] = 1'b1;
                    w_gidx     = SEL_W'(i);
                    w_gdata    = bus.in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && bus.in_valid[i] && (i >= int'(r_rr_ptr))) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_gidx     = SEL_W'(i);
                    w_gdata    = bus.in_data[i*WIDTH +: WIDTH];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!w_found && bus.in_valid[i] && (i < int'(r_rr_ptr))) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_gidx     = SEL_W'(i);
                    w_gdata    = bus.in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_in_ready = {N{w_load_en}} & w_grant;
    assign w_xfer     = |(bus.in_valid & w_in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_gdata;
            r_out_src   <= w_gidx;
            r_out_valid <= 1'b1;
            if (!bus.mode) begin
                r_rr_ptr <= (w_gidx == SEL_W'(N-1)) ? '0 : w_gidx + SEL_W'(1);
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer; successor to the fixed 4:1 combinational mux.
- Each channel has a valid/ready handshake. The block selects one channel per transfer, either by round-robin arbitration or by a fixed select input.
- The selected word is registered into a single output stage.
- It sits between multiple producer streams and one consumer stream.

Parameters:
- WIDTH, 4, data width per channel.
- N, 4, number of input channels; N >= 2.
- SEL_W, $clog2(N), width of the select and source-index fields; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode = 1.
- out_data  output  WIDTH  registered data.
- out_src  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_src = 0, round-robin pointer rr_ptr = 0. in_ready is therefore 0 on every channel except where load_en allows; load_en = 1 with out_valid = 0.
- load_en = !out_valid | out_ready. The output stage can accept a word when it is empty or being drained in the same cycle.
- Eligibility:
  - mode = 0: channel i is eligible if in_valid[i] = 1.
  - mode = 1: only channel sel is eligible. sel >= N (possible when N is not a power of 2) makes no channel eligible.
- Grant (combinational, one-hot or zero):
  - mode = 0: the first eligible channel searching upward from rr_ptr, wrapping N-1 -> 0.
  - mode = 1: channel sel, if eligible.
- in_ready[i] = load_en & grant[i]. At most one bit is set. in_ready must not depend on in_valid of the same channel beyond grant selection, and there is no combinational path from in_valid to out_*.
- Transfer: when in_valid[g] & in_ready[g] at a clock edge:
  - out_data <= channel g data, out_src <= g, out_valid <= 1.
  - In mode 0 only, rr_ptr <= (g == N-1) ? 0 : g+1.
  - In mode 1, rr_ptr is unchanged.
- Drain without refill (out_valid & out_ready with no grant): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid are held stable, and every in_ready is 0.
- Throughput: 1 word per cycle when out_ready stays high. Latency: 1 cycle from input handshake to out_valid.
- Fairness: in mode 0 with all N channels continuously valid, each channel is served exactly once per N transfers, in order rr_ptr, rr_ptr+1, ...
- Mode or sel change while out_valid = 1 does not affect the held output word; it applies only to the next grant.
- Reset asserted mid-stream drops the held word; out_valid falls asynchronously.

Test Plan:
- Reset, then mode = 0, N = 4, WIDTH = 4, all in_valid = 1, data {a,b,c,d} on channels 0..3, out_ready = 1 -> out_data sequence a,b,c,d,a,... with out_src 0,1,2,3,0, one word per cycle, first out_valid one cycle after release.
- mode = 0, only channels 1 and 3 valid (data 5, 9), rr_ptr = 2 -> first transfer from channel 3 (out_data 9, out_src 3), then channel 1 (5), alternating.
- mode = 1, sel = 2, all channels valid -> only in_ready[2] ever asserts, and every output word is channel 2's data.
- mode = 1 with sel = 2 and in_valid[2] = 0 -> out_valid stays 0.
- Backpressure: hold out_ready = 0 for 3 cycles after a transfer of value 'hc -> out_data stays 'hc, out_valid stays 1 and in_ready = 0 throughout. On out_ready = 1 the next word loads in the same cycle.
- Assert rst_n = 0 while out_valid = 1 mid-stream -> out_valid, out_data and out_src drop to 0 immediately without a clock edge. After release, arbitration restarts at channel 0.
